instr_mem_port_arbiter: RTL and testbench
=========================================

// Module: instr_mem_port_arbiter
// PURPOSE
//  Sits directly upstream of the instruction RAM/boot-ROM wrapper and owns its single memory port.
//  Arbitrates between the core fetch port (read-only) and the bus-side loader port (read/write).
//  Both ports use the req/gnt/rvalid protocol; the arbiter returns the 1-cycle-latency read data to the granted owner.
//  Fetch wins by default; a starvation counter guarantees loader progress.
// PARAMETERS
//  ADDR_WIDTH  16  byte address width; MSB=1 selects boot ROM (matches downstream wrapper)
//  DATA_WIDTH  32  data width; BE width = DATA_WIDTH/8
//  STARVE_MAX  4   consecutive loader-denied cycles before the loader is forced a grant (>=1)
// PORTS
//  clk             in   1              clock
//  rst_n           in   1              async reset, active low
//  core_req_i      in   1              fetch request
//  core_addr_i     in   ADDR_WIDTH     fetch byte address
//  core_gnt_o      out  1              fetch request accepted this cycle
//  core_rvalid_o   out  1              fetch data valid
//  core_rdata_o    out  DATA_WIDTH     fetch data
//  bus_req_i       in   1              loader request
//  bus_we_i        in   1              loader write enable
//  bus_be_i        in   DATA_WIDTH/8   loader byte enables
//  bus_addr_i      in   ADDR_WIDTH     loader byte address
//  bus_wdata_i     in   DATA_WIDTH     loader write data
//  bus_gnt_o       out  1              loader request accepted
//  bus_rvalid_o    out  1              loader response (read data or write ack)
//  bus_rdata_o     out  DATA_WIDTH     loader read data (0 for write acks)
//  mem_en_o        out  1              to wrapper en_i
//  mem_addr_o      out  ADDR_WIDTH     to wrapper addr_i
//  mem_wdata_o     out  DATA_WIDTH     to wrapper wdata_i
//  mem_we_o        out  1              to wrapper we_i
//  mem_be_o        out  DATA_WIDTH/8   to wrapper be_i
//  mem_rdata_i     in   DATA_WIDTH     from wrapper rdata_o, valid 1 cycle after mem_en_o
// BEHAVIOUR
//  Clock/reset: one clock clk; rst_n asynchronous active-low.
//  Reset: gnt/rvalid/mem_en/mem_we = 0; rdata/addr/wdata/be = 0; owner_q=NONE; starve_cnt=0.
//  Grant is combinational and one-hot; at most one grant per cycle; gnt only while the matching req is high.
//  mem_* outputs are combinational muxes of the granted port; mem_en_o = core_gnt_o | bus_gnt_o (except ROM write, below).
//  Core-port drive: mem_we_o=0, mem_be_o=all ones, mem_wdata_o=0.
//  Arbitration:
//   core_req & !bus_req -> core.  bus_req & !core_req -> bus.
//   Both requesting: core, unless starve_cnt == STARVE_MAX, then bus.
//  Starvation counter:
//   starve_cnt increments (saturating at STARVE_MAX) each cycle bus_req=1 and bus_gnt=0.
//   It clears on bus_gnt or when bus_req=0.
//  Response FSM: owner_q in {NONE, CORE, BUS, BUS_WR}, loaded every cycle from the grant:
//   core_gnt -> CORE; bus_gnt & !we -> BUS; bus_gnt & we -> BUS_WR; no grant -> NONE.
//  Response timing (cycle after grant):
//   CORE   -> core_rvalid_o=1, core_rdata_o = mem_rdata_i.
//   BUS    -> bus_rvalid_o=1,  bus_rdata_o  = mem_rdata_i.
//   BUS_WR -> bus_rvalid_o=1,  bus_rdata_o  = 0.
//   NONE   -> both rvalid 0.
//   rdata outputs are 0 whenever the matching rvalid is 0.
//  Latency: request with gnt in cycle N -> rvalid in cycle N+1; full throughput, one transfer per cycle.
//   No response back-pressure; requesters always accept rvalid.
//  Boot-ROM write (bus_we_i=1, bus_addr_i[ADDR_WIDTH-1]=1): granted normally, mem_en_o=0, mem_we_o=0.
//   Acked as BUS_WR; no memory access is issued.
//  Boot-ROM reads from either port pass through; the wrapper selects the ROM.
//  Address/alignment: addresses pass through unmodified; the low 2 bits are not checked.
//  Reset mid-transfer: owner_q clears; a pending rvalid is dropped; requesters re-issue.
// TESTING
//  Core-only reads of 0x0000, 0x0004, 0x0008 with back-to-back req -> gnt each cycle; rvalid one cycle later with RAM data; mem_we=0.
//  Bus write 0x0010 (wdata=0xDEADBEEF, be=0xF), then bus read 0x0010 -> write ack rdata=0; read returns 0xDEADBEEF one cycle after gnt.
//  Core and bus req held high continuously (STARVE_MAX=4) -> core wins 4 cycles, bus granted on cycle 5, counter clears; pattern repeats 4:1.
//  Bus write to 0x8000 (ROM region) -> bus_gnt=1, mem_en_o=0, bus_rvalid=1 next cycle; later ROM read of 0x8000 is unchanged.
//  Core read to 0x8004 -> mem_en=1, addr MSB set; core_rvalid next cycle carries ROM data.
//  rst_n asserted the cycle after a core grant -> core_rvalid stays 0; all outputs 0; starve_cnt=0 after release.

Source files
------------

// File: rtl/instr_mem_port_arbiter.sv
// Single-port arbiter in front of the instruction RAM/boot-ROM wrapper.
// The core fetch port wins by default; a starvation counter forces loader grants.
module instr_mem_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    core_req_i,
  input  logic [ADDR_WIDTH-1:0]   core_addr_i,
  output logic                    core_gnt_o,
  output logic                    core_rvalid_o,
  output logic [DATA_WIDTH-1:0]   core_rdata_o,
  input  logic                    bus_req_i,
  input  logic                    bus_we_i,
  input  logic [DATA_WIDTH/8-1:0] bus_be_i,
  input  logic [ADDR_WIDTH-1:0]   bus_addr_i,
  input  logic [DATA_WIDTH-1:0]   bus_wdata_i,
  output logic                    bus_gnt_o,
  output logic                    bus_rvalid_o,
  output logic [DATA_WIDTH-1:0]   bus_rdata_o,
  output logic                    mem_en_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int CNT_WIDTH = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_WIDTH-1:0] STARVE_LIMIT = CNT_WIDTH'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_BUS,
    OWN_BUS_WR
  } owner_e;

  owner_e                owner_q, owner_d;
  logic [CNT_WIDTH-1:0]  starve_cnt_q, starve_cnt_d;
  logic                  starved;
  logic                  rom_write;

  always_comb begin
    starved    = (starve_cnt_q == STARVE_LIMIT);
    bus_gnt_o  = bus_req_i && (!core_req_i || starved);
    core_gnt_o = core_req_i && !bus_gnt_o;
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned and no latch is inferred.
    starve_cnt_d = '0;
    if (bus_req_i && !bus_gnt_o) begin
      starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
  end

  // Writes into the boot-ROM window are acknowledged but never reach the wrapper.
  always_comb begin
    rom_write   = bus_gnt_o && bus_we_i && bus_addr_i[ADDR_WIDTH-1];
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (core_gnt_o) begin
      mem_en_o   = 1'b1;
      mem_addr_o = core_addr_i;
      mem_be_o   = '1;
    end else if (bus_gnt_o) begin
      mem_en_o    = !rom_write;
      mem_we_o    = bus_we_i && !rom_write;
      mem_addr_o  = bus_addr_i;
      mem_wdata_o = bus_wdata_i;
      mem_be_o    = bus_be_i;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (core_gnt_o) begin
      owner_d = OWN_CORE;
    end else if (bus_gnt_o) begin
      owner_d = bus_we_i ? OWN_BUS_WR : OWN_BUS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      owner_q      <= OWN_NONE;
      starve_cnt_q <= '0;
    end else begin
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Read data is forwarded only to the owner of last cycle's grant; otherwise zero.
  always_comb begin
    core_rvalid_o = 1'b0;
    core_rdata_o  = '0;
    bus_rvalid_o  = 1'b0;
    bus_rdata_o   = '0;
    unique case (owner_q)
      OWN_CORE: begin
        core_rvalid_o = 1'b1;
        core_rdata_o  = mem_rdata_i;
      end
      OWN_BUS: begin
        bus_rvalid_o = 1'b1;
        bus_rdata_o  = mem_rdata_i;
      end
      OWN_BUS_WR: bus_rvalid_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_mem_port_arbiter.sv
// Bench for instr_mem_port_arbiter: wrapper memory model, rule-level scoreboard
// checked every falling edge, and directed scenarios with literal expectations.
module tb_instr_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          core_req_i = 1'b0;
  logic [AW-1:0] core_addr_i = '0;
  logic          core_gnt_o, core_rvalid_o;
  logic [DW-1:0] core_rdata_o;
  logic          bus_req_i = 1'b0, bus_we_i = 1'b0;
  logic [BW-1:0] bus_be_i = '0;
  logic [AW-1:0] bus_addr_i = '0;
  logic [DW-1:0] bus_wdata_i = '0;
  logic          bus_gnt_o, bus_rvalid_o;
  logic [DW-1:0] bus_rdata_o;
  logic          mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [BW-1:0] mem_be_o;
  logic [DW-1:0] mem_rdata_i;

  int n_checks = 0;
  int n_fail = 0;

  instr_mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_gnt_o(core_gnt_o),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .bus_req_i(bus_req_i), .bus_we_i(bus_we_i), .bus_be_i(bus_be_i),
    .bus_addr_i(bus_addr_i), .bus_wdata_i(bus_wdata_i), .bus_gnt_o(bus_gnt_o),
    .bus_rvalid_o(bus_rvalid_o), .bus_rdata_o(bus_rdata_o),
    .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Initial contents: RAM word i = 0x1000_0000+i, ROM word i = 0xB007_0000+i.
  function automatic logic [DW-1:0] init_word(input logic rom, input int idx);
    return rom ? (32'hB007_0000 + DW'(idx)) : (32'h1000_0000 + DW'(idx));
  endfunction

  // Wrapper stand-in: 1-cycle read latency, ROM ignores writes, junk data when idle.
  logic [DW-1:0] w_ram [64];
  logic [DW-1:0] w_rom [64];
  logic [15:0]   cyc = '0;
  initial begin
    for (int i = 0; i < 64; i++) begin
      w_ram[i] = init_word(1'b0, i);
      w_rom[i] = init_word(1'b1, i);
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 16'd1;
    if (mem_en_o) begin
      mem_rdata_i <= mem_addr_o[AW-1] ? w_rom[mem_addr_o[7:2]] : w_ram[mem_addr_o[7:2]];
      if (mem_we_o && !mem_addr_o[AW-1]) begin
        for (int b = 0; b < BW; b++) begin
          if (mem_be_o[b]) w_ram[mem_addr_o[7:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
      end
    end else begin
      mem_rdata_i <= {16'hBAD0, cyc};
    end
  end

  // Scoreboard: expected grants from the priority rules, one pending response slot.
  logic [DW-1:0] m_ram [64];
  logic [DW-1:0] m_rom [64];
  int            m_starve = 0;
  logic          m_pend_valid = 1'b0, m_pend_core = 1'b0, m_pend_wr = 1'b0;
  logic [DW-1:0] m_pend_data = '0;
  initial begin
    for (int i = 0; i < 64; i++) begin
      m_ram[i] = init_word(1'b0, i);
      m_rom[i] = init_word(1'b1, i);
    end
  end

  always @(negedge clk) begin
    logic e_bus, e_core, e_rom_wr, e_core_rv, e_bus_rv;
    logic [DW-1:0] e_core_rd, e_bus_rd, word;
    logic [AW-1:0] ga;
    if (!rst_n) begin
      m_starve     = 0;
      m_pend_valid = 1'b0;
      check("rst core_gnt", core_gnt_o, 0);
      check("rst bus_gnt", bus_gnt_o, 0);
      check("rst core_rvalid", core_rvalid_o, 0);
      check("rst bus_rvalid", bus_rvalid_o, 0);
      check("rst core_rdata", core_rdata_o, 0);
      check("rst bus_rdata", bus_rdata_o, 0);
      check("rst mem_en", mem_en_o, 0);
      check("rst mem_we", mem_we_o, 0);
    end else begin
      e_bus     = bus_req_i && (!core_req_i || m_starve >= SMAX);
      e_core    = core_req_i && !e_bus;
      e_rom_wr  = e_bus && bus_we_i && bus_addr_i[AW-1];
      e_core_rv = m_pend_valid && m_pend_core;
      e_bus_rv  = m_pend_valid && !m_pend_core;
      e_core_rd = e_core_rv ? m_pend_data : '0;
      e_bus_rd  = (e_bus_rv && !m_pend_wr) ? m_pend_data : '0;
      check("core_gnt", core_gnt_o, e_core);
      check("bus_gnt", bus_gnt_o, e_bus);
      check("core_rvalid", core_rvalid_o, e_core_rv);
      check("core_rdata", core_rdata_o, e_core_rd);
      check("bus_rvalid", bus_rvalid_o, e_bus_rv);
      check("bus_rdata", bus_rdata_o, e_bus_rd);
      check("mem_en", mem_en_o, (e_core || e_bus) && !e_rom_wr);
      check("mem_we", mem_we_o, e_bus && bus_we_i && !e_rom_wr);
      if (e_core) begin
        check("mem_addr core", mem_addr_o, core_addr_i);
        check("mem_be core", mem_be_o, 4'hF);
        check("mem_wdata core", mem_wdata_o, 0);
      end else if (e_bus) begin
        check("mem_addr bus", mem_addr_o, bus_addr_i);
        check("mem_be bus", mem_be_o, bus_be_i);
        check("mem_wdata bus", mem_wdata_o, bus_wdata_i);
      end
      ga = e_core ? core_addr_i : bus_addr_i;
      m_pend_valid = e_core || e_bus;
      m_pend_core  = e_core;
      m_pend_wr    = e_bus && bus_we_i;
      m_pend_data  = ga[AW-1] ? m_rom[ga[7:2]] : m_ram[ga[7:2]];
      if (e_bus && bus_we_i && !bus_addr_i[AW-1]) begin
        word = m_ram[bus_addr_i[7:2]];
        for (int b = 0; b < BW; b++) begin
          if (bus_be_i[b]) word[8*b +: 8] = bus_wdata_i[8*b +: 8];
        end
        m_ram[bus_addr_i[7:2]] = word;
      end
      if (bus_req_i && !e_bus) m_starve = (m_starve < SMAX) ? m_starve + 1 : m_starve;
      else m_starve = 0;
    end
  end

  // One cycle: inputs change just after the rising edge, outputs read just after the falling edge.
  task automatic drive(input logic rst, input logic creq, input logic [AW-1:0] caddr,
                       input logic breq, input logic bwe, input logic [BW-1:0] bbe,
                       input logic [AW-1:0] baddr, input logic [DW-1:0] bwd);
    @(posedge clk);
    #1;
    rst_n       = rst;
    core_req_i  = creq;
    core_addr_i = caddr;
    bus_req_i   = breq;
    bus_we_i    = bwe;
    bus_be_i    = bbe;
    bus_addr_i  = baddr;
    bus_wdata_i = bwd;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
  endtask
  task automatic core_rd(input logic [AW-1:0] a);
    drive(1'b1, 1'b1, a, 1'b0, 1'b0, '0, '0, '0);
  endtask
  task automatic bus_wr(input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
    drive(1'b1, 1'b0, '0, 1'b1, 1'b1, be, a, d);
  endtask
  task automatic bus_rd(input logic [AW-1:0] a);
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 4'hF, a, '0);
  endtask
  task automatic both(input logic [AW-1:0] ca, input logic [AW-1:0] ba);
    drive(1'b1, 1'b1, ca, 1'b1, 1'b0, 4'hF, ba, '0);
  endtask

  initial begin
    logic [9:0] pat10;
    logic [4:0] pat5;
    repeat (3) drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    check("reset mem_en literal", mem_en_o, 0);
    check("reset core_rvalid literal", core_rvalid_o, 0);
    idle();

    core_rd(16'h0000);
    check("fetch0 gnt", core_gnt_o, 1);
    core_rd(16'h0004);
    check("fetch0 rvalid", core_rvalid_o, 1);
    check("fetch0 data", core_rdata_o, 32'h1000_0000);
    core_rd(16'h0008);
    check("fetch4 data", core_rdata_o, 32'h1000_0001);
    check("fetch mem_we", mem_we_o, 0);
    idle();
    check("fetch8 data", core_rdata_o, 32'h1000_0002);

    bus_wr(16'h0010, 4'hF, 32'hDEAD_BEEF);
    check("bus wr gnt", bus_gnt_o, 1);
    bus_rd(16'h0010);
    check("bus wr ack rvalid", bus_rvalid_o, 1);
    check("bus wr ack data", bus_rdata_o, 0);
    idle();
    check("bus rd back", bus_rdata_o, 32'hDEAD_BEEF);
    bus_wr(16'h0014, 4'b0101, 32'h1122_3344);
    bus_rd(16'h0014);
    idle();
    check("bus partial be", bus_rdata_o, 32'h1022_0044);
    idle();

    for (int i = 0; i < 10; i++) begin
      both(16'h0020, 16'h0030);
      pat10[i] = bus_gnt_o;
    end
    check("starve 4:1 pattern", pat10, 10'h210);
    idle();
    idle();

    bus_wr(16'h8000, 4'hF, 32'h1234_5678);
    check("rom wr gnt", bus_gnt_o, 1);
    check("rom wr mem_en", mem_en_o, 0);
    bus_rd(16'h8000);
    check("rom wr ack", bus_rvalid_o, 1);
    check("rom wr ack data", bus_rdata_o, 0);
    idle();
    check("rom rd unchanged", bus_rdata_o, 32'hB007_0000);

    core_rd(16'h8004);
    check("rom fetch en", mem_en_o, 1);
    check("rom fetch addr", mem_addr_o, 16'h8004);
    idle();
    check("rom fetch data", core_rdata_o, 32'hB007_0001);

    both(16'h0040, 16'h0044);
    both(16'h0040, 16'h0044);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    check("mid-reset core_rvalid", core_rvalid_o, 0);
    check("mid-reset core_rdata", core_rdata_o, 0);
    check("mid-reset mem_en", mem_en_o, 0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    idle();
    for (int i = 0; i < 5; i++) begin
      both(16'h0048, 16'h004C);
      pat5[i] = bus_gnt_o;
    end
    check("post-reset starve", pat5, 5'b10000);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
